// File: rtl/mem_sram_resp.sv
// Mem-bus target: services mem_req_t requests from a local word RAM and returns
// in-order mem_resp_t responses after a fixed latency through a credit-bounded FIFO.
package mem_sram_resp_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        wr;
  } mem_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } mem_resp_t;
endpackage

module mem_sram_resp
  import mem_sram_resp_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned RESP_DP = 2
) (
  input  logic      clk,
  input  logic      rstn,
  input  logic      req_valid,
  output logic      req_ready,
  input  mem_req_t  req,
  output logic      resp_valid,
  input  logic      resp_ready,
  output mem_resp_t resp
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = (RESP_DP > 1) ? $clog2(RESP_DP) : 1;
  localparam int unsigned CW = $clog2(RESP_DP + 1);

  logic [31:0]   ram_q [DEPTH];
  logic [31:0]   fifo_q [RESP_DP];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q, rd_ptr_n, wr_ptr_n;
  logic [CW-1:0] fcnt_q, fcnt_n, out_cnt_q, out_cnt_n;
  logic          req_ready_q, resp_valid_q;
  mem_resp_t     resp_q;
  logic          accept, pop, push;
  logic [AW-1:0] widx;
  logic [31:0]   acc_data, push_data, head_n;
  logic          unused_addr;

  assign accept      = req_valid && req_ready;
  assign pop         = resp_valid && resp_ready;
  assign widx        = req.addr[AW+1:2];
  assign acc_data    = req.wr ? 32'h0 : ram_q[widx];
  assign unused_addr = ^{req.addr[31:AW+2], req.addr[1:0]};

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp       = resp_q;

  // Byte-masked write on the accept edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && req.wr) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (req.wmask[b]) ram_q[widx][8*b +: 8] <= req.wdata[8*b +: 8];
      end
    end
  end

  // Fixed-delay response pipeline; the FIFO write edge is its last stage.
  if (LATENCY == 1) begin : g_lat1
    assign push      = accept;
    assign push_data = acc_data;
  end else begin : g_latn
    logic [LATENCY-2:0] v_q;
    logic [31:0]        d_q [LATENCY-1];

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        v_q <= '0;
        for (int unsigned i = 0; i < LATENCY - 1; i++) d_q[i] <= 32'h0;
      end else begin
        v_q[0] <= accept;
        d_q[0] <= acc_data;
        for (int unsigned i = 1; i < LATENCY - 1; i++) begin
          v_q[i] <= v_q[i-1];
          d_q[i] <= d_q[i-1];
        end
      end
    end

    assign push      = v_q[LATENCY-2];
    assign push_data = d_q[LATENCY-2];
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RESP_DP - 1)) ? '0 : p + PW'(1);
  endfunction

  // Next-state for FIFO pointers, counters and the registered head.
  always_comb begin
    rd_ptr_n  = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_n  = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    fcnt_n    = fcnt_q + CW'(push) - CW'(pop);
    out_cnt_n = out_cnt_q + CW'(accept) - CW'(pop);
    head_n    = fifo_q[rd_ptr_n];
    if (push && (wr_ptr_q == rd_ptr_n)) head_n = push_data;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      fcnt_q       <= '0;
      out_cnt_q    <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_q       <= '0;
    end else begin
      rd_ptr_q     <= rd_ptr_n;
      wr_ptr_q     <= wr_ptr_n;
      fcnt_q       <= fcnt_n;
      out_cnt_q    <= out_cnt_n;
      // First edge out of reset also marks reset done.
      req_ready_q  <= (out_cnt_n < CW'(RESP_DP));
      resp_valid_q <= (fcnt_n != '0);
      resp_q       <= (fcnt_n != '0) ? '{rdata: head_n, err: 1'b0} : '0;
    end
  end

  fifo_overflow: assert property (@(posedge clk) disable iff (!rstn)
    !(push && (fcnt_q == CW'(RESP_DP))));

endmodule

// File: tb/tb_mem_sram_resp.sv
// Directed bench for mem_sram_resp: scoreboarded LATENCY=1 instance plus a LATENCY=3 instance.
module tb_mem_sram_resp;
  import mem_sram_resp_pkg::*;

  logic      clk = 1'b0;
  logic      rstn = 1'b0;
  logic      a_req_valid = 1'b0, a_req_ready, a_resp_valid, a_resp_ready = 1'b1;
  mem_req_t  a_req = '0;
  mem_resp_t a_resp;
  logic      b_req_valid = 1'b0, b_req_ready, b_resp_valid, b_resp_ready = 1'b1;
  mem_req_t  b_req = '0;
  mem_resp_t b_resp;

  int          n_checks = 0;
  int          n_fail = 0;
  int          acc_cnt = 0;
  int          cyc = 0;
  logic [31:0] sb [$];
  logic [31:0] mdl [1024];
  logic [31:0] last_rdata = 32'h0;

  mem_sram_resp #(.DEPTH(1024), .LATENCY(1), .RESP_DP(2)) u_a (
    .clk(clk), .rstn(rstn), .req_valid(a_req_valid), .req_ready(a_req_ready), .req(a_req),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready), .resp(a_resp));

  mem_sram_resp #(.DEPTH(1024), .LATENCY(3), .RESP_DP(4)) u_b (
    .clk(clk), .rstn(rstn), .req_valid(b_req_valid), .req_ready(b_req_ready), .req(b_req),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp(b_resp));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: model predicts at accept, responses are checked at handshake.
  always @(negedge clk) begin
    if (rstn) begin
      if (a_resp_valid && a_resp_ready) begin
        chk("stale_resp", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) chk("rdata", a_resp.rdata, sb.pop_front());
        chk("resp_err", 32'(a_resp.err), 32'd0);
        last_rdata = a_resp.rdata;
      end else if (a_resp_valid && sb.size() != 0) begin
        chk("hold", a_resp.rdata, sb[0]);
      end else if (!a_resp_valid) begin
        chk("idle_zero", a_resp.rdata | 32'(a_resp.err), 32'd0);
      end
      if (a_req_valid && a_req_ready) begin
        acc_cnt++;
        if (a_req.wr) begin
          for (int b = 0; b < 4; b++)
            if (a_req.wmask[b]) mdl[a_req.addr[11:2]][8*b +: 8] = a_req.wdata[8*b +: 8];
          sb.push_back(32'h0);
        end else begin
          sb.push_back(mdl[a_req.addr[11:2]]);
        end
      end
    end
  end

  task automatic send(input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wmask, input logic wr);
    int w;
    a_req = '{addr: addr, wdata: wdata, wmask: wmask, wr: wr};
    a_req_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!a_req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!a_req_ready) chk("req_timeout", 32'(a_req_ready), 32'd1);
    @(posedge clk);
    #1;
    a_req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((sb.size() != 0 || a_resp_valid) && w < 200) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int a0, t0, cnt;
    // Reset values and release timing.
    #12;
    chk("rst_req_ready", 32'(a_req_ready), 32'd0);
    chk("rst_resp_valid", 32'(a_resp_valid), 32'd0);
    chk("rst_resp", a_resp.rdata | 32'(a_resp.err), 32'd0);
    @(posedge clk); #1; rstn = 1'b1;
    @(negedge clk);
    chk("rel_ready_early", 32'(a_req_ready), 32'd0);
    @(negedge clk);
    chk("rel_ready", 32'(a_req_ready), 32'd1);
    @(posedge clk); #1;

    // Byte-masked writes then read.
    send(32'h10, 32'hAABBCCDD, 4'hF, 1'b1);
    send(32'h10, 32'h11223344, 4'h5, 1'b1);
    send(32'h10, 32'h0, 4'h0, 1'b0);
    wait_idle();
    chk("bytemask", last_rdata, 32'hAA22CC44);

    // Upper address bits alias modulo DEPTH.
    send(32'h0000_1004, 32'hDEADBEEF, 4'hF, 1'b1);
    send(32'h4, 32'h0, 4'h0, 1'b0);
    wait_idle();
    chk("alias", last_rdata, 32'hDEADBEEF);

    // Back-pressure: two accepts, then stall until the first drain.
    a_resp_ready = 1'b0;
    a0 = acc_cnt;
    send(32'h10, 32'h0, 4'h0, 1'b0);
    send(32'h4, 32'h0, 4'h0, 1'b0);
    a_req = '{addr: 32'h10, wdata: 32'h0, wmask: 4'h0, wr: 1'b0};
    a_req_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("bp_accepts", 32'(acc_cnt - a0), 32'd2);
    chk("bp_ready_low", 32'(a_req_ready), 32'd0);
    a_resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_pre_drain", 32'(a_req_ready), 32'd0);
    @(negedge clk);
    chk("bp_ready_return", 32'(a_req_ready), 32'd1);
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    wait_idle();
    chk("bp_total", 32'(acc_cnt - a0), 32'd3);

    // Reset with responses queued: everything outstanding is dropped.
    a_resp_ready = 1'b0;
    send(32'h4, 32'h0, 4'h0, 1'b0);
    send(32'h10, 32'h0, 4'h0, 1'b0);
    rstn = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_ready", 32'(a_req_ready), 32'd0);
    chk("mid_rst_valid", 32'(a_resp_valid), 32'd0);
    chk("mid_rst_resp", a_resp.rdata | 32'(a_resp.err), 32'd0);
    @(posedge clk); #1; rstn = 1'b1;
    a_resp_ready = 1'b1;
    @(negedge clk);
    chk("mid_rel_ready_early", 32'(a_req_ready), 32'd0);
    @(negedge clk);
    chk("mid_rel_ready", 32'(a_req_ready), 32'd1);
    repeat (4) @(negedge clk);
    chk("no_stale", 32'(a_resp_valid), 32'd0);
    @(posedge clk); #1;
    send(32'h1010, 32'h0, 4'h0, 1'b0);
    wait_idle();
    chk("ram_kept", last_rdata, 32'hAA22CC44);

    // Streaming: 100 writes then 100 back-to-back reads, one per cycle.
    for (int i = 0; i < 100; i++) send(32'(i) << 2, 32'(i), 4'hF, 1'b1);
    t0 = cyc;
    for (int i = 0; i < 100; i++) send(32'(i) << 2, 32'h0, 4'h0, 1'b0);
    chk("stream_cycles", 32'(cyc - t0), 32'd100);
    wait_idle();
    chk("stream_last", last_rdata, 32'd99);

    // LATENCY=3 instance: first response appears after edge k+2.
    b_req = '{addr: 32'h8, wdata: 32'h5A5A1234, wmask: 4'hF, wr: 1'b1};
    b_req_valid = 1'b1;
    @(negedge clk);
    chk("b_ready", 32'(b_req_ready), 32'd1);
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("b_idle", 32'(b_resp_valid), 32'd0);
    b_req = '{addr: 32'h8, wdata: 32'h0, wmask: 4'h0, wr: 1'b0};
    b_req_valid = 1'b1;
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    @(negedge clk);
    chk("lat_k", 32'(b_resp_valid), 32'd0);
    @(negedge clk);
    chk("lat_k1", 32'(b_resp_valid), 32'd0);
    @(negedge clk);
    chk("lat_k2", 32'(b_resp_valid), 32'd1);
    chk("lat_rdata", b_resp.rdata, 32'h5A5A1234);
    @(posedge clk); #1;

    // LATENCY=3 with RESP_DP=4 sustains one accept per cycle.
    cnt = 0;
    b_req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (b_req_ready) cnt++;
      @(posedge clk); #1;
    end
    b_req_valid = 1'b0;
    chk("b_throughput", 32'(cnt), 32'd8);
    repeat (12) @(posedge clk);
    #1;
    chk("b_drained", 32'(b_resp_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
